// File: rtl/instr_mem_pipelined.sv
// Byte-addressed instruction memory with LATENCY-stage valid/ready pipeline, stall-all backpressure and flush.
// Define IMEM_WRITE_PORT_EN to add a byte-enabled program-load write port (otherwise the memory is a ROM).
module instr_mem_pipelined #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 512,
    parameter int                LATENCY   = 1,
    parameter string             INIT_FILE = "",
    parameter logic [DATA_W-1:0] NOP_WORD  = 32'h00000013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_instr,
    output logic [ADDR_W-1:0]   rsp_addr,
    output logic                rsp_err
`ifdef IMEM_WRITE_PORT_EN
    ,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be
`endif
);

    localparam int OFF   = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TOP   = IDX_W + OFF;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("instr_mem_pipelined: LATENCY must be in 1..4");
    end

    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    logic              stg_v_q  [LATENCY];
    logic [ADDR_W-1:0] stg_a_q  [LATENCY];
    logic              stg_e_q  [LATENCY];
    logic              stg_v_d  [LATENCY];
    logic [ADDR_W-1:0] stg_a_d  [LATENCY];
    logic              stg_e_d  [LATENCY];
    logic              stg_in_v [LATENCY];
    logic [ADDR_W-1:0] stg_in_a [LATENCY];
    logic              stg_in_e [LATENCY];
    logic [DATA_W-1:0] instr_q;

    logic advance;
    logic accept;
    logic req_mis;
    logic req_oor;
    logic rd_en;
    logic [IDX_W-1:0] rd_idx;

    assign advance   = !stg_v_q[LATENCY-1] || rsp_ready;
    assign req_ready = advance && !flush && !rst;
    assign accept    = req_valid && req_ready;
    assign req_mis   = |req_addr[OFF-1:0];
    assign req_oor   = |req_addr[ADDR_W-1:TOP];

    // Each stage takes its predecessor (stage 0 takes the request) only when the whole pipe advances.
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign stg_in_v[gi] = accept;
            assign stg_in_a[gi] = req_addr;
            assign stg_in_e[gi] = req_mis || req_oor;
        end else begin : g_body
            assign stg_in_v[gi] = stg_v_q[gi-1];
            assign stg_in_a[gi] = stg_a_q[gi-1];
            assign stg_in_e[gi] = stg_e_q[gi-1];
        end
        assign stg_v_d[gi] = flush ? 1'b0 : (advance ? stg_in_v[gi] : stg_v_q[gi]);
        assign stg_a_d[gi] = advance ? stg_in_a[gi] : stg_a_q[gi];
        assign stg_e_d[gi] = advance ? stg_in_e[gi] : stg_e_q[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg_v_q[i] <= 1'b0;
                stg_a_q[i] <= '0;
                stg_e_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                stg_v_q[i] <= stg_v_d[i];
                stg_a_q[i] <= stg_a_d[i];
                stg_e_q[i] <= stg_e_d[i];
            end
        end
    end

    // The word is read as the fetch enters the final stage, so data lands with its valid/addr/err.
    assign rd_en  = advance && !flush && stg_in_v[LATENCY-1];
    assign rd_idx = stg_in_a[LATENCY-1][TOP-1:OFF];

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_WORD;
        end else if (rd_en) begin
            if (stg_in_e[LATENCY-1]) instr_q <= NOP_WORD;
            else                     instr_q <= mem_q[rd_idx];
        end
    end

`ifdef IMEM_WRITE_PORT_EN
    logic             wr_ok;
    logic [IDX_W-1:0] wr_idx;

    assign wr_idx = wr_addr[TOP-1:OFF];
    assign wr_ok  = wr_en && (wr_addr[OFF-1:0] == '0) && (wr_addr[ADDR_W-1:TOP] == '0);

    // Non-blocking update gives read-first behaviour against a read of the same word this edge.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end
`endif

    assign rsp_valid = stg_v_q[LATENCY-1];
    assign rsp_addr  = stg_a_q[LATENCY-1];
    assign rsp_err   = stg_e_q[LATENCY-1];
    assign rsp_instr = instr_q;

endmodule
